// File: rtl/fifo_wr_adapter.sv
// Frame-aware write adapter in front of a FIFO: a 2-entry skid buffer decouples the
// upstream handshake from the FIFO full flag, with frame, stall and overlength tracking.
module fifo_wr_adapter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_LEN    = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  wr_clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  full,
    output logic                  wr_enb,
    output logic [DATA_WIDTH-1:0] input_data,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic                  len_err
);

    localparam int unsigned LenW = $clog2(MAX_LEN + 1);
    localparam logic [LenW-1:0] MaxLen = LenW'(MAX_LEN);

    typedef enum logic {StIdle, StFrame} state_e;

    state_e                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic [LenW-1:0]       word_cnt_q, word_cnt_d, word_inc;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, stall_cnt_q;
    logic                  len_err_q;
    logic                  push, pop, at_max, last_in, force_close, stall;

    assign push        = s_valid && s_ready;
    assign pop         = wr_enb;
    assign word_inc    = word_cnt_q + 1'b1;
    assign at_max      = (word_inc == MaxLen);
    assign last_in     = s_last || at_max;
    assign force_close = push && !s_last && at_max;
    assign stall       = (occ_q != 2'd0) && full;

    // FSM: state register
    always_ff @(posedge wr_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state (a forced close looks like a last word here)
    always_comb begin
        state_d = state_q;
        if (push) begin
            state_d = last_in ? StIdle : StFrame;
        end
    end

    // FSM: outputs; rstn gates s_ready so it drops the instant reset asserts
    always_comb begin
        s_ready = rstn && (occ_q != 2'd2) && ((state_q == StFrame) || en);
    end

    assign wr_enb     = (occ_q != 2'd0) && !full;
    assign input_data = data0_q;
    assign frame_cnt  = frame_cnt_q;
    assign stall_cnt  = stall_cnt_q;
    assign len_err    = len_err_q;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (push) begin
            word_cnt_d = last_in ? '0 : word_inc;
        end
    end

    // Head only moves when a younger entry exists, so input_data holds once drained
    always_comb begin
        occ_d   = occ_q;
        data0_d = data0_q;
        last0_d = last0_q;
        data1_d = data1_q;
        last1_d = last1_q;
        case ({push, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    data0_d = s_data;
                    last0_d = last_in;
                end else begin
                    data1_d = s_data;
                    last1_d = last_in;
                end
            end
            2'b01: begin
                occ_d = occ_q - 2'd1;
                if (occ_q == 2'd2) begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                end
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    data0_d = s_data;
                    last0_d = last_in;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = s_data;
                    last1_d = last_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rstn) begin
        if (!rstn) begin
            occ_q      <= 2'd0;
            data0_q    <= '0;
            last0_q    <= 1'b0;
            data1_q    <= '0;
            last1_q    <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            data0_q    <= data0_d;
            last0_q    <= last0_d;
            data1_q    <= data1_d;
            last1_q    <= last1_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_ff @(posedge wr_clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            if (pop && last0_q) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (force_close) begin
                len_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Directed bench for fifo_wr_adapter, built with MAX_LEN=4 and CNT_WIDTH=4 so the
// overlength and saturation corners are reachable in a few cycles.
module tb_fifo_wr_adapter;

    logic       wr_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       full = 1'b0;
    logic       wr_enb;
    logic [7:0] input_data;
    logic [3:0] frame_cnt;
    logic [3:0] stall_cnt;
    logic       len_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] wr_log[$];
    int         wr_cyc[$];

    fifo_wr_adapter #(
        .DATA_WIDTH(8),
        .MAX_LEN   (4),
        .CNT_WIDTH (4)
    ) dut (
        .wr_clk    (wr_clk),
        .rstn      (rstn),
        .en        (en),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .full      (full),
        .wr_enb    (wr_enb),
        .input_data(input_data),
        .frame_cnt (frame_cnt),
        .stall_cnt (stall_cnt),
        .len_err   (len_err)
    );

    always #5 wr_clk = ~wr_clk;

    always @(posedge wr_clk) cyc <= cyc + 1;

    // Writes happen at the next rising edge; capture them mid-cycle
    always @(negedge wr_clk) begin
        if (rstn && wr_enb) begin
            wr_log.push_back(input_data);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        full    = 1'b0;
        en      = 1'b1;
        rstn    = 1'b0;
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        rstn = 1'b1;
        @(posedge wr_clk);
        #1;
        wr_log.delete();
        wr_cyc.delete();
    endtask

    task automatic push_word(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge wr_clk);
        while (!s_ready && n < 50) begin
            @(negedge wr_clk);
            n++;
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL push_timeout word=%h s_ready=%b required=1", d, s_ready);
        end
        @(posedge wr_clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        en   = 1'b1;
        #1;
        total += 6;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
        if (wr_enb !== 1'b0) begin bad++; $display("FAIL rst_wr_enb got=%b exp=0", wr_enb); end
        if (input_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", input_data); end
        if (frame_cnt !== 4'd0) begin bad++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
        if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
        if (len_err !== 1'b0) begin bad++; $display("FAIL rst_len_err got=%b exp=0", len_err); end
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        rstn = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready_en1 got=%b exp=1", s_ready); end
        en = 1'b0;
        #1;
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL post_rst_ready_en0 got=%b exp=0", s_ready); end
        en = 1'b1;
    endtask

    task automatic test_frame3();
        logic [7:0] exp_d[3] = '{8'h11, 8'h22, 8'h33};
        do_reset();
        push_word(8'h11, 1'b0);
        push_word(8'h22, 1'b0);
        push_word(8'h33, 1'b1);
        repeat (3) @(posedge wr_clk);
        #1;
        total++;
        if (wr_log.size() != 3) begin bad++; $display("FAIL f3_count got=%0d exp=3", wr_log.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] got = (i < wr_log.size()) ? wr_log[i] : 8'hxx;
            total++;
            if (got !== exp_d[i]) begin bad++; $display("FAIL f3_data[%0d] got=%h exp=%h", i, got, exp_d[i]); end
        end
        for (int i = 1; i < 3; i++) begin
            int gap = (i < wr_cyc.size()) ? wr_cyc[i] - wr_cyc[i-1] : -1;
            total++;
            if (gap != 1) begin bad++; $display("FAIL f3_consecutive[%0d] gap=%0d exp=1", i, gap); end
        end
        total += 2;
        if (frame_cnt !== 4'd1) begin bad++; $display("FAIL f3_frame_cnt got=%0d exp=1", frame_cnt); end
        if (stall_cnt !== 4'd0) begin bad++; $display("FAIL f3_stall_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        full = 1'b1;
        push_word(8'h5A, 1'b0);
        push_word(8'hA5, 1'b1);
        // one stall edge with occ=1 so far; four more with occ=2
        repeat (4) @(posedge wr_clk);
        #1;
        total += 4;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL st_s_ready got=%b exp=0", s_ready); end
        if (wr_enb !== 1'b0) begin bad++; $display("FAIL st_wr_enb got=%b exp=0", wr_enb); end
        if (stall_cnt !== 4'd5) begin bad++; $display("FAIL st_stall_cnt got=%0d exp=5", stall_cnt); end
        if (wr_log.size() != 0) begin bad++; $display("FAIL st_no_write got=%0d exp=0", wr_log.size()); end
        full = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;
        total += 5;
        if (wr_log.size() != 2) begin bad++; $display("FAIL st_drain_count got=%0d exp=2", wr_log.size()); end
        if (wr_log.size() > 0 && wr_log[0] !== 8'h5A) begin bad++; $display("FAIL st_word0 got=%h exp=5a", wr_log[0]); end
        if (wr_log.size() > 1 && wr_log[1] !== 8'hA5) begin bad++; $display("FAIL st_word1 got=%h exp=a5", wr_log[1]); end
        if (stall_cnt !== 4'd5) begin bad++; $display("FAIL st_stall_hold got=%0d exp=5", stall_cnt); end
        if (frame_cnt !== 4'd1) begin bad++; $display("FAIL st_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_enable();
        logic [7:0] exp_d[4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_reset();
        en      = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h77;
        s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge wr_clk);
            total++;
            if (s_ready !== 1'b0) begin bad++; $display("FAIL en0_ready[%0d] got=%b exp=0", i, s_ready); end
        end
        @(posedge wr_clk);
        #1;
        s_valid = 1'b0;
        total++;
        if (wr_log.size() != 0) begin bad++; $display("FAIL en0_no_write got=%0d exp=0", wr_log.size()); end
        en = 1'b1;
        push_word(8'hA1, 1'b0);
        en = 1'b0;
        push_word(8'hA2, 1'b0);
        push_word(8'hA3, 1'b0);
        push_word(8'hA4, 1'b1);
        repeat (3) @(posedge wr_clk);
        #1;
        total++;
        if (wr_log.size() != 4) begin bad++; $display("FAIL en_mid_count got=%0d exp=4", wr_log.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] got = (i < wr_log.size()) ? wr_log[i] : 8'hxx;
            total++;
            if (got !== exp_d[i]) begin bad++; $display("FAIL en_mid_data[%0d] got=%h exp=%h", i, got, exp_d[i]); end
        end
        total += 2;
        if (frame_cnt !== 4'd1) begin bad++; $display("FAIL en_mid_frame_cnt got=%0d exp=1", frame_cnt); end
        if (s_ready !== 1'b0) begin bad++; $display("FAIL en0_idle_ready got=%b exp=0", s_ready); end
        en = 1'b1;
    endtask

    task automatic test_len_err();
        do_reset();
        push_word(8'h01, 1'b0);
        push_word(8'h02, 1'b0);
        push_word(8'h03, 1'b0);
        total++;
        if (len_err !== 1'b0) begin bad++; $display("FAIL le_before got=%b exp=0", len_err); end
        push_word(8'h04, 1'b0);
        total++;
        if (len_err !== 1'b1) begin bad++; $display("FAIL le_set got=%b exp=1", len_err); end
        repeat (2) @(posedge wr_clk);
        #1;
        total++;
        if (frame_cnt !== 4'd1) begin bad++; $display("FAIL le_forced_frame got=%0d exp=1", frame_cnt); end
        push_word(8'h05, 1'b0);
        push_word(8'h06, 1'b1);
        repeat (3) @(posedge wr_clk);
        #1;
        total += 3;
        if (frame_cnt !== 4'd2) begin bad++; $display("FAIL le_frame_cnt got=%0d exp=2", frame_cnt); end
        if (len_err !== 1'b1) begin bad++; $display("FAIL le_sticky got=%b exp=1", len_err); end
        if (wr_log.size() != 6) begin bad++; $display("FAIL le_count got=%0d exp=6", wr_log.size()); end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] got = (i < wr_log.size()) ? wr_log[i] : 8'hxx;
            logic [7:0] exp_v = 8'(i + 1);
            total++;
            if (got !== exp_v) begin bad++; $display("FAIL le_data[%0d] got=%h exp=%h", i, got, exp_v); end
        end
    endtask

    // Runs straight after test_len_err so reset has nonzero counters and len_err to clear
    task automatic test_reset_mid();
        full = 1'b1;
        push_word(8'h31, 1'b0);
        push_word(8'h32, 1'b0);
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL rm_occ2_ready got=%b exp=0", s_ready); end
        full = 1'b0;
        #1;
        total += 2;
        if (wr_enb !== 1'b1) begin bad++; $display("FAIL rm_pre_wr_enb got=%b exp=1", wr_enb); end
        if (input_data !== 8'h31) begin bad++; $display("FAIL rm_pre_data got=%h exp=31", input_data); end
        #1;
        rstn = 1'b0;
        #1;
        total += 6;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL rm_s_ready got=%b exp=0", s_ready); end
        if (wr_enb !== 1'b0) begin bad++; $display("FAIL rm_wr_enb got=%b exp=0", wr_enb); end
        if (input_data !== 8'h00) begin bad++; $display("FAIL rm_data got=%h exp=00", input_data); end
        if (frame_cnt !== 4'd0) begin bad++; $display("FAIL rm_frame_cnt got=%0d exp=0", frame_cnt); end
        if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rm_stall_cnt got=%0d exp=0", stall_cnt); end
        if (len_err !== 1'b0) begin bad++; $display("FAIL rm_len_err got=%b exp=0", len_err); end
        @(negedge wr_clk);
        rstn = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL rm_post_ready got=%b exp=1", s_ready); end
        wr_log.delete();
        wr_cyc.delete();
        @(posedge wr_clk);
        #1;
        push_word(8'h44, 1'b1);
        repeat (2) @(posedge wr_clk);
        #1;
        total += 3;
        if (wr_log.size() != 1) begin bad++; $display("FAIL rm_count got=%0d exp=1", wr_log.size()); end
        if (wr_log.size() > 0 && wr_log[0] !== 8'h44) begin bad++; $display("FAIL rm_word got=%h exp=44", wr_log[0]); end
        if (frame_cnt !== 4'd1) begin bad++; $display("FAIL rm_frame_cnt_after got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_stall_sat();
        do_reset();
        full = 1'b1;
        push_word(8'h99, 1'b1);
        repeat (14) @(posedge wr_clk);
        #1;
        total++;
        if (stall_cnt !== 4'd14) begin bad++; $display("FAIL sat_14 got=%0d exp=14", stall_cnt); end
        @(posedge wr_clk);
        #1;
        total++;
        if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_15 got=%0d exp=15", stall_cnt); end
        repeat (5) @(posedge wr_clk);
        #1;
        total++;
        if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
        full = 1'b0;
        repeat (2) @(posedge wr_clk);
        #1;
        total += 3;
        if (wr_log.size() != 1) begin bad++; $display("FAIL sat_count got=%0d exp=1", wr_log.size()); end
        if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_after got=%0d exp=15", stall_cnt); end
        if (frame_cnt !== 4'd1) begin bad++; $display("FAIL sat_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_frame3();
        test_stall();
        test_enable();
        test_len_err();
        test_reset_mid();
        test_stall_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_adapter.md
FIFO_WR_ADAPTER -- requirements
Module: fifo_wr_adapter

Interface
REQ-001 Parameter DATA_WIDTH, 8, width of the data path; equals the FIFO data width.
REQ-002 Parameter MAX_LEN, 64, maximum words per frame; legal range 2..65535.
REQ-003 Parameter CNT_WIDTH, 16, width of frame_cnt and stall_cnt.
REQ-004 wr_clk  in  1  write-domain clock; all logic is on its rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  enable for starting new frames.
REQ-007 s_valid  in  1  upstream word valid.
REQ-008 s_data  in  DATA_WIDTH  upstream word.
REQ-009 s_last  in  1  marks the final word of a frame.
REQ-010 s_ready  out  1  adapter can accept a word this cycle.
REQ-011 full  in  1  FIFO full flag, write domain.
REQ-012 wr_enb  out  1  FIFO write enable.
REQ-013 input_data  out  DATA_WIDTH  FIFO write data.
REQ-014 frame_cnt  out  CNT_WIDTH  count of frames fully written into the FIFO.
REQ-015 stall_cnt  out  CNT_WIDTH  count of cycles stalled by full; saturating.
REQ-016 len_err  out  1  sticky flag: a frame exceeded MAX_LEN.

Function
REQ-017 A 2-entry skid buffer shall hold {data, last}; occupancy occ is 0..2.
REQ-018 s_ready = (occ < 2) and (state != IDLE or en); it is combinational from registers and en only, with no path from s_valid.
REQ-019 An upstream transfer shall occur when s_valid && s_ready; the word goes into the buffer tail.
REQ-020 wr_enb = (occ != 0) && !full; input_data = head entry data; wr_enb low implies input_data holds its last value.
REQ-021 A FIFO write shall occur when wr_enb=1; the head pops in the same cycle.
REQ-022 Simultaneous push and pop shall leave occ unchanged and preserve word order.
REQ-023 Push at occ=2 is impossible by REQ-018; pop at occ=0 is impossible by REQ-020.
REQ-024 Latency: a word accepted at edge N into an empty buffer appears on input_data after edge N and is written at edge N+1 if full=0.
REQ-025 FSM states: IDLE (no frame open) and FRAME (frame open).
REQ-026 FSM transitions: IDLE->FRAME on an accepted word with s_last=0; IDLE stays IDLE on an accepted word with s_last=1 (single-word frame); FRAME->IDLE on an accepted word with s_last=1 or on a forced close.
REQ-027 en low shall block only frame starts (IDLE); an open frame continues to completion regardless of en.
REQ-028 The word counter shall count accepted words in the current frame; it clears on frame close.
REQ-029 Forced close: when the accepted word is number MAX_LEN with s_last=0, the stored last bit is forced to 1, len_err is set, and the FSM goes to IDLE.
REQ-030 After a forced close, following words are treated as a new frame.
REQ-031 frame_cnt shall increment by 1, wrapping modulo 2^CNT_WIDTH, on each FIFO write whose head last bit is 1.
REQ-032 stall_cnt shall increment on each cycle with occ != 0 && full, and saturate at all-ones.
REQ-033 len_err shall clear only on reset.

Reset
REQ-034 rstn low shall immediately force occ=0, FSM=IDLE, word counter=0, wr_enb=0, s_ready=0, input_data=0, frame_cnt=0, stall_cnt=0, len_err=0.
REQ-035 Buffered words are discarded on reset; an open frame is abandoned and not counted.
REQ-036 After rstn rises, the first edge shall behave normally, with s_ready = en.

Verification
REQ-037 Frame of 3 words (0x11, 0x22, 0x33 with last on the third), en=1, full=0 -> wr_enb high 3 consecutive cycles, data in order, frame_cnt=1, stall_cnt=0.
REQ-038 full=1 held 5 cycles while 2 words are buffered -> s_ready=0, wr_enb=0, stall_cnt=5; after full drops, both words are written in order with no loss or duplication.
REQ-039 en=0 in IDLE with s_valid=1 -> s_ready=0 and no writes; en drops after the first word of a 4-word frame -> all 4 words are written and frame_cnt increments.
REQ-040 MAX_LEN=4 and a 6-word frame with last on the sixth -> 4th word is written with last forced, len_err=1, frame_cnt=2 after the 6th word.
REQ-041 rstn pulsed low mid-frame with occ=2 -> all outputs take the REQ-034 values immediately; a subsequent 1-word frame gives frame_cnt=1.
REQ-042 Set stall_cnt to all-ones via CNT_WIDTH=4 with a 20-cycle stall -> stall_cnt holds at 15.
